// File: rtl/mux_arb_pkg.sv
// Shared types, default sizes and the round-robin pick used by the mux-sharing arbiter.
package mux_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int unsigned MAX_N        = 16;
    localparam int unsigned DEF_N        = 10;
    localparam int unsigned DEF_SELW     = 4;
    localparam int unsigned DEF_MAX_HOLD = 8;

    // First set request after `last`, wrapping at n-1 -> 0; returns 0 when none is set.
    function automatic logic [3:0] rr_pick(input logic [MAX_N-1:0] req,
                                           input logic [3:0]       last,
                                           input int unsigned      n);
        logic [3:0]  win;
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_N; k++) begin
            if (k <= n) begin
                idx = 32'(last) + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[3:0]]) begin
                    win   = idx[3:0];
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mux_share_arbiter_if.sv
// Requester-side bus of the mux-sharing arbiter: requests, mux data, grant and registered result.
interface mux_share_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned SELW = DEF_SELW
);
    logic [N-1:0]    req;
    logic [N-1:0]    i;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] s;
    logic            busy;
    logic            y_q;

    modport master (output req, i, input gnt, s, busy, y_q);
    modport slave  (input req, i, output gnt, s, busy, y_q);
endinterface

// File: rtl/mux_nx1.sv
// Combinational N:1 single-bit mux; out-of-range selects read as 0.
module mux_nx1 #(
    parameter int unsigned N    = 10,
    parameter int unsigned SELW = 4
) (
    input  logic [N-1:0]    i,
    input  logic [SELW-1:0] s,
    output logic            y
);
    always_comb begin
        y = 1'b0;
        if (32'(s) < N) y = i[s];
    end
endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter owning the select of a shared N:1 mux; registers the selected bit.
// Optional grant timeout: define MUX_ARB_TIMEOUT_EN to bound a grant to MAX_HOLD cycles.
module mux_share_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned SELW     = DEF_SELW,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input logic               clk,
    input logic               rst_n,
    mux_share_arbiter_if.slave bus
);
    if (N < 2 || N > MAX_N || (1 << SELW) < N || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
        $error("mux_share_arbiter: parameter out of range");
    end

    state_t          state;
    logic [3:0]      last;
    logic [N-1:0]    gnt_r;
    logic [SELW-1:0] s_r;
    logic            busy_r;
    logic            y_r;

    logic [N-1:0]    gnt_next;
    logic [3:0]      win;
    logic            mux_y;
    logic            req_s;
    logic            timeout;

    assign win   = rr_pick(MAX_N'(bus.req), last, N);
    assign req_s = bus.req[s_r];

    always_comb begin
        gnt_next      = '0;
        gnt_next[win] = 1'b1;
    end

    mux_nx1 #(.N(N), .SELW(SELW)) u_mux (
        .i (bus.i),
        .s (s_r),
        .y (mux_y)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // Reloaded to 1 in IDLE so the grant edge starts the count; saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            hold_cnt <= 8'd1;
        end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign timeout = (hold_cnt >= 8'(MAX_HOLD));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last   <= 4'(N - 1);
            gnt_r  <= '0;
            s_r    <= '0;
            busy_r <= 1'b0;
            y_r    <= 1'b0;
        end else begin
            if (busy_r) y_r <= mux_y;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_r  <= gnt_next;
                        s_r    <= SELW'(win);
                        busy_r <= 1'b1;
                        last   <= win;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req_s || timeout) begin
                        gnt_r  <= '0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.s    = s_r;
    assign bus.busy = busy_r;
    assign bus.y_q  = y_r;
endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench for mux_share_arbiter: directed scenarios plus random traffic vs a cycle model.
module tb_mux_share_arbiter;
    localparam int N        = 10;
    localparam int SELW     = 4;
    localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_share_arbiter_if #(.N(N), .SELW(SELW)) bus ();

    mux_share_arbiter #(.N(N), .SELW(SELW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the mux, where the rotation stands, the last sampled bit.
    bit m_busy;
    int m_s;
    int m_last;
    int m_hold;
    bit m_y;

    int s_order[$];
    int y_order[$];
    bit prev_busy;
    int busy2_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_busy) eg[m_s] = 1'b1;
        check("gnt",  32'(bus.gnt),  32'(eg));
        check("s",    32'(bus.s),    32'(m_s));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("y_q",  32'(bus.y_q),  32'(m_y));
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_s    = 0;
        m_last = N - 1;
        m_hold = 0;
        m_y    = 1'b0;
    endtask

    // Called one time unit after an active edge; reset pulse stays clear of the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step();
        bit n_busy, n_y, found;
        int n_s, n_last, n_hold, idx;
        n_busy = m_busy; n_s = m_s; n_last = m_last; n_hold = m_hold; n_y = m_y;
        if (m_busy) n_y = bus.i[m_s];
        if (!m_busy) begin
            if (bus.req != '0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (!found && bus.req[idx]) begin
                        found = 1'b1;
                        n_s   = idx;
                    end
                end
                n_busy = 1'b1;
                n_last = n_s;
                n_hold = 1;
            end
        end else if (!bus.req[m_s] || (TO_EN && m_hold >= MAX_HOLD)) begin
            n_busy = 1'b0;
        end else if (m_hold < 255) begin
            n_hold = m_hold + 1;
        end
        @(posedge clk);
        #1;
        m_busy = n_busy; m_s = n_s; m_last = n_last; m_hold = n_hold; m_y = n_y;
        check_all();
    endtask

    initial begin
        bus.req = '0;
        bus.i   = '0;
        rst_n   = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Single requester holds for 5 cycles
        bus.req = 10'b0000001000;
        repeat (5) step();
        bus.req = '0;
        repeat (2) step();

        // Round-robin with data path pattern
        @(posedge clk); #1;
        do_reset();
        bus.i = 10'b1010101011;
        s_order.delete();
        y_order.delete();
        prev_busy = 1'b0;
        for (int c = 0; c < 22; c++) begin
            bus.req = m_busy ? ~(10'(1) << m_s) : '1;
            step();
            if (prev_busy) y_order.push_back(int'(bus.y_q));
            if (bus.busy && !prev_busy) s_order.push_back(int'(bus.s));
            prev_busy = bus.busy;
        end
        check("rr_count", 32'(s_order.size()), 32'd11);
        for (int g = 0; g < 11 && g < s_order.size(); g++)
            check("rr_order", 32'(s_order[g]), 32'(g % 10));
        check("y_count", 32'(y_order.size()), 32'd11);
        begin
            int y_exp[10] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 1};
            for (int g = 0; g < 10 && g < y_order.size(); g++)
                check("y_order", 32'(y_order[g]), 32'(y_exp[g]));
        end

        // Asynchronous reset in the middle of a grant
        bus.req = '0;
        step();
        do_reset();
        bus.i   = '1;
        bus.req = 10'b0000001000;
        repeat (2) step();
        check("pre_rst_y", 32'(bus.y_q), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        #1;
        rst_n   = 1'b1;
        bus.req = 10'b0000000001;
        step();
        check("after_rst_s", 32'(bus.s), 32'd0);
        bus.req = '0;
        step();

        // Two requesters held continuously
        do_reset();
        bus.req = (10'(1) << 7) | (10'(1) << 2);
        busy2_cycles = 0;
        s_order.delete();
        prev_busy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.busy && bus.s == 4'd2) busy2_cycles++;
            if (bus.busy && !prev_busy) s_order.push_back(int'(bus.s));
            prev_busy = bus.busy;
        end
`ifdef MUX_ARB_TIMEOUT_EN
        check("to_order_len", 32'(s_order.size() >= 3), 32'd1);
        if (s_order.size() >= 3) begin
            check("to_order0", 32'(s_order[0]), 32'd2);
            check("to_order1", 32'(s_order[1]), 32'd7);
            check("to_order2", 32'(s_order[2]), 32'd2);
        end
`else
        check("hold_s2_cycles", 32'(busy2_cycles), 32'd20);
        check("hold_grants", 32'(s_order.size()), 32'd1);
`endif
        bus.req = '0;
        step();

        // Random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.i = 10'($urandom);
            if ($urandom_range(0, 3) == 0) bus.req = 10'($urandom) & 10'($urandom);
            if ($urandom_range(0, 7) == 0 && m_busy) bus.req[m_s] = 1'b0;
            if ($urandom_range(0, 150) == 0) do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
